// File: rtl/commit_queue_if.sv
// -----------------------------------------------------------------------------
// commit_queue_pkg / IPushCommit
//
// Purpose: shared types for the in-order retirement controller and the
// dispatch-side handshake used to allocate commit ids.
//
// Types:
//   EntryKind    - write-back (KIND_WB) or branch (KIND_BRANCH) entry
//   CommitEntry  - one reorder slot as written by dispatch
//   CommitInfo   - register-file commit port
//   BranchResult - fetch-redirect port for retired branches
//
// IPushCommit ports:
//   en           - dispatch request (master -> slave)
//   commit_entry - entry to allocate (master -> slave)
//   commit_id    - id the entry receives if accepted (slave -> master)
// -----------------------------------------------------------------------------
package commit_queue_pkg;

   typedef enum logic {
      KIND_WB     = 1'b0,
      KIND_BRANCH = 1'b1
   } EntryKind;

   typedef struct packed {
      EntryKind    kind;
      logic [4:0]  dest_logic;
      logic [31:0] data;
      logic        fin;
      logic [1:0]  notify;
      logic [15:0] current_pc;
      logic [15:0] new_pc;
      logic        taken;
      logic        raise;
   } CommitEntry;

   typedef struct packed {
      logic        en;
      logic [4:0]  dest_logic;
      logic [31:0] data;
   } CommitInfo;

   typedef struct packed {
      logic        en;
      logic        miss;
      logic        taken;
      logic [31:0] current_pc;
      logic [31:0] jump_addr;
   } BranchResult;

endpackage

interface IPushCommit;
   import commit_queue_pkg::*;

   logic       en;
   CommitEntry commit_entry;
   logic [7:0] commit_id;

   modport master (output en, output commit_entry, input commit_id);
   modport slave  (input en, input commit_entry, output commit_id);
endinterface

// File: rtl/commit_queue.sv
// -----------------------------------------------------------------------------
// commit_queue
//
// Purpose: in-order retirement controller. Dispatch allocates a slot (commit
// id) per instruction; execution units later mark slots finished. The oldest
// entry retires once it is finished and has no pending notify bits, one entry
// per cycle. A retiring mispredicted branch discards everything in flight.
//
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   push           - IPushCommit slave: en/commit_entry in, commit_id out
//   full           - queue holds DEPTH entries
//   wb_en/id/data  - write-back completion
//   br_en/id/taken/raise - branch completion
//   notify_clr     - clears notify bits of the head entry
//   commit         - registered register-file commit
//   branch_result  - registered retired-branch outcome
//   flush          - registered pulse after a mispredict retires
// -----------------------------------------------------------------------------
module commit_queue
   import commit_queue_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   IPushCommit.slave   push,
   output logic        full,
   input  logic        wb_en,
   input  logic [7:0]  wb_id,
   input  logic [31:0] wb_data,
   input  logic        br_en,
   input  logic [7:0]  br_id,
   input  logic        br_taken,
   input  logic        br_raise,
   input  logic [1:0]  notify_clr,
   output CommitInfo   commit,
   output BranchResult branch_result,
   output logic        flush
);

   localparam int PW = $clog2(DEPTH);

   CommitEntry         slots [DEPTH];
   logic [DEPTH-1:0]   valid;
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic [PW:0]        count;

   CommitEntry         head_entry;
   logic               head_ready;
   logic               retire_flush;
   logic               push_ok;
   logic [PW-1:0]      wb_slot;
   logic [PW-1:0]      br_slot;
   logic               wb_hit;
   logic               br_hit;
   logic [15:0]        next_pc;

   // Retire decision is made purely on registered slot state, so a completion
   // or notify clear seen at an edge can only let the head retire one edge later.
   assign head_entry   = slots[head];
   assign head_ready   = valid[head] && head_entry.fin && (head_entry.notify == 2'b00);
   assign retire_flush = head_ready && (head_entry.kind == KIND_BRANCH) && head_entry.raise;
   assign next_pc      = head_entry.current_pc + 16'd1;

   assign full           = (count == (PW+1)'(DEPTH));
   assign push.commit_id = 8'(tail);

   // A push coinciding with a mispredict retire is dropped along with the rest
   // of the in-flight state; the same goes for completions at that edge.
   assign push_ok = push.en && !full && !retire_flush;

   assign wb_slot = wb_id[PW-1:0];
   assign br_slot = br_id[PW-1:0];
   assign wb_hit  = wb_en && (wb_id <= 8'(DEPTH - 1)) && valid[wb_slot]
                    && (slots[wb_slot].kind == KIND_WB) && !retire_flush;
   assign br_hit  = br_en && (br_id <= 8'(DEPTH - 1)) && valid[br_slot]
                    && (slots[br_slot].kind == KIND_BRANCH) && !retire_flush;

   // Slot payload storage. Meaningless while the valid bit is clear, so it
   // carries no reset. Push always targets an invalid slot and completions only
   // touch valid ones, so the writes below never collide on the same field.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         slots[tail] <= push.commit_entry;
      end
      if (wb_hit) begin
         slots[wb_slot].data <= wb_data;
         slots[wb_slot].fin  <= 1'b1;
      end
      if (br_hit) begin
         slots[br_slot].fin   <= 1'b1;
         slots[br_slot].taken <= br_taken;
         slots[br_slot].raise <= br_raise;
      end
      if (valid[head]) begin
         slots[head].notify <= head_entry.notify & ~notify_clr;
      end
   end

   // Pointer/occupancy bookkeeping and registered retirement outputs. Event
   // strobes default low each cycle; payload fields hold their last value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid         <= '0;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         commit        <= '0;
         branch_result <= '0;
         flush         <= 1'b0;
      end else begin
         commit.en        <= 1'b0;
         branch_result.en <= 1'b0;
         flush            <= 1'b0;

         if (head_ready) begin
            if (head_entry.kind == KIND_WB) begin
               commit.en         <= 1'b1;
               commit.dest_logic <= head_entry.dest_logic;
               commit.data       <= head_entry.data;
            end else begin
               branch_result.en         <= 1'b1;
               branch_result.miss       <= head_entry.raise;
               branch_result.taken      <= head_entry.taken;
               branch_result.current_pc <= 32'(head_entry.current_pc);
               branch_result.jump_addr  <= head_entry.taken ? 32'(head_entry.new_pc)
                                                            : 32'(next_pc);
            end
         end

         if (retire_flush) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            flush <= 1'b1;
         end else begin
            if (head_ready) begin
               valid[head] <= 1'b0;
               head        <= head + PW'(1);
            end
            if (push_ok) begin
               valid[tail] <= 1'b1;
               tail        <= tail + PW'(1);
            end
            case ({push_ok, head_ready})
               2'b10:   count <= count + (PW+1)'(1);
               2'b01:   count <= count - (PW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_commit_queue.sv
// -----------------------------------------------------------------------------
// tb_commit_queue
//
// Directed bench for commit_queue with DEPTH=8: in-order retirement of
// out-of-order completions, full/overflow handling, mispredict flush, pc
// wrap on a not-taken branch, notify gating and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_commit_queue;
   import commit_queue_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        full;
   logic        wb_en;
   logic [7:0]  wb_id;
   logic [31:0] wb_data;
   logic        br_en;
   logic [7:0]  br_id;
   logic        br_taken;
   logic        br_raise;
   logic [1:0]  notify_clr;
   CommitInfo   commitOut;
   BranchResult branchOut;
   logic        flushOut;

   int checkCount = 0;
   int passCount  = 0;
   int stray;

   IPushCommit pushBus ();

   commit_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .push          (pushBus),
      .full          (full),
      .wb_en         (wb_en),
      .wb_id         (wb_id),
      .wb_data       (wb_data),
      .br_en         (br_en),
      .br_id         (br_id),
      .br_taken      (br_taken),
      .br_raise      (br_raise),
      .notify_clr    (notify_clr),
      .commit        (commitOut),
      .branch_result (branchOut),
      .flush         (flushOut)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock edge, land 1ns after it, and drop single-cycle strobes
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      pushBus.en = 1'b0;
      wb_en      = 1'b0;
      br_en      = 1'b0;
      notify_clr = 2'b00;
   endtask

   function automatic CommitEntry wbEntry(input logic [4:0] dest, input logic [31:0] data,
                                          input logic fin, input logic [1:0] notify);
      CommitEntry e;
      e            = '0;
      e.kind       = KIND_WB;
      e.dest_logic = dest;
      e.data       = data;
      e.fin        = fin;
      e.notify     = notify;
      return e;
   endfunction

   function automatic CommitEntry brEntry(input logic [15:0] cur, input logic [15:0] target);
      CommitEntry e;
      e            = '0;
      e.kind       = KIND_BRANCH;
      e.current_pc = cur;
      e.new_pc     = target;
      return e;
   endfunction

   task automatic pushWb(input logic [4:0] dest, input logic [31:0] data,
                         input logic fin, input logic [1:0] notify);
      pushBus.en           = 1'b1;
      pushBus.commit_entry = wbEntry(dest, data, fin, notify);
   endtask

   task automatic completeWb(input logic [7:0] id, input logic [31:0] data);
      wb_en   = 1'b1;
      wb_id   = id;
      wb_data = data;
   endtask

   initial begin
      reset                = 1'b1;
      pushBus.en           = 1'b0;
      pushBus.commit_entry = '0;
      wb_en                = 1'b0;
      wb_id                = '0;
      wb_data              = '0;
      br_en                = 1'b0;
      br_id                = '0;
      br_taken             = 1'b0;
      br_raise             = 1'b0;
      notify_clr           = 2'b00;

      // Reset state
      applyStimulus();
      checkOutput("resetCommitEn", 64'(commitOut), 64'd0);
      checkOutput("resetBranch", 64'(branchOut.en), 64'd0);
      checkOutput("resetFlush", 64'(flushOut), 64'd0);
      checkOutput("resetFull", 64'(full), 64'd0);
      checkOutput("resetId", 64'(pushBus.commit_id), 64'd0);
      reset = 1'b0;

      // Three wb entries completed out of order retire in program order
      checkOutput("allocId0", 64'(pushBus.commit_id), 64'd0);
      pushWb(5'd1, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("allocId1", 64'(pushBus.commit_id), 64'd1);
      pushWb(5'd2, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("allocId2", 64'(pushBus.commit_id), 64'd2);
      pushWb(5'd3, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      completeWb(8'd2, 32'h22);
      applyStimulus();
      checkOutput("noCommitYoungDone", 64'(commitOut.en), 64'd0);
      completeWb(8'd0, 32'h00);
      applyStimulus();
      checkOutput("noCommitSameEdge", 64'(commitOut.en), 64'd0);
      completeWb(8'd1, 32'h11);
      applyStimulus();
      checkOutput("retire0", 64'(commitOut), 64'({1'b1, 5'd1, 32'h00}));
      applyStimulus();
      checkOutput("retire1", 64'(commitOut), 64'({1'b1, 5'd2, 32'h11}));
      applyStimulus();
      checkOutput("retire2", 64'(commitOut), 64'({1'b1, 5'd3, 32'h22}));
      applyStimulus();
      checkOutput("retireIdle", 64'(commitOut.en), 64'd0);

      // Fill to DEPTH starting from head=tail=3, ids wrap through 7 -> 0
      for (int i = 0; i < DEPTH; i++) begin
         pushWb(5'(8 + i), 32'h0, 1'b0, 2'b00);
         applyStimulus();
      end
      checkOutput("fullSet", 64'(full), 64'd1);
      checkOutput("fullTailWrap", 64'(pushBus.commit_id), 64'd3);
      pushWb(5'd31, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("extraPushTail", 64'(pushBus.commit_id), 64'd3);
      checkOutput("extraPushFull", 64'(full), 64'd1);
      completeWb(8'd3, 32'hAB);
      applyStimulus();
      // Retire while full: the push at this edge must be dropped (no bypass)
      pushWb(5'd20, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("retireWhileFull", 64'(commitOut), 64'({1'b1, 5'd8, 32'hAB}));
      checkOutput("noBypassTail", 64'(pushBus.commit_id), 64'd3);
      checkOutput("noBypassFull", 64'(full), 64'd0);
      completeWb(8'd4, 32'hCD);
      applyStimulus();
      // Retire and push at the same edge: occupancy stays at DEPTH-1
      pushWb(5'd21, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("pushRetire", 64'(commitOut), 64'({1'b1, 5'd9, 32'hCD}));
      checkOutput("pushRetireTail", 64'(pushBus.commit_id), 64'd4);
      checkOutput("pushRetireFull", 64'(full), 64'd0);
      pushWb(5'd22, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("refill", 64'(full), 64'd1);
      checkOutput("refillTail", 64'(pushBus.commit_id), 64'd5);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("cleanupFull", 64'(full), 64'd0);

      // Taken mispredict flushes younger entries, including a completed one
      pushBus.en           = 1'b1;
      pushBus.commit_entry = brEntry(16'h00FF, 16'h0400);
      applyStimulus();
      pushWb(5'd5, 32'h55, 1'b1, 2'b00);
      applyStimulus();
      pushWb(5'd6, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      br_en    = 1'b1;
      br_id    = 8'd0;
      br_taken = 1'b1;
      br_raise = 1'b1;
      completeWb(8'd2, 32'h66);
      applyStimulus();
      checkOutput("branchNotYet", 64'(branchOut.en), 64'd0);
      pushWb(5'd7, 32'h0, 1'b1, 2'b00);
      applyStimulus();
      checkOutput("missEn", 64'(branchOut.en), 64'd1);
      checkOutput("missMiss", 64'(branchOut.miss), 64'd1);
      checkOutput("missTaken", 64'(branchOut.taken), 64'd1);
      checkOutput("missJump", 64'(branchOut.jump_addr), 64'h400);
      checkOutput("missPc", 64'(branchOut.current_pc), 64'hFF);
      checkOutput("flushPulse", 64'(flushOut), 64'd1);
      checkOutput("flushId", 64'(pushBus.commit_id), 64'd0);
      checkOutput("flushNoCommit", 64'(commitOut.en), 64'd0);
      applyStimulus();
      checkOutput("flushOneCycle", 64'(flushOut), 64'd0);
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         if (commitOut.en || branchOut.en) stray++;
         applyStimulus();
      end
      checkOutput("noYoungerCommit", 64'(stray), 64'd0);

      // Not-taken branch: fall-through address wraps at 16 bits
      pushBus.en           = 1'b1;
      pushBus.commit_entry = brEntry(16'hFFFF, 16'h1234);
      applyStimulus();
      br_en    = 1'b1;
      br_id    = 8'd0;
      br_taken = 1'b0;
      br_raise = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("ntEn", 64'(branchOut.en), 64'd1);
      checkOutput("ntMiss", 64'(branchOut.miss), 64'd0);
      checkOutput("ntTaken", 64'(branchOut.taken), 64'd0);
      checkOutput("ntJumpWrap", 64'(branchOut.jump_addr), 64'h0);
      checkOutput("ntPc", 64'(branchOut.current_pc), 64'hFFFF);
      checkOutput("ntNoFlush", 64'(flushOut), 64'd0);
      checkOutput("ntTail", 64'(pushBus.commit_id), 64'd1);

      // Finished entry held by notify until it is cleared
      pushWb(5'd7, 32'h77, 1'b1, 2'b01);
      applyStimulus();
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         if (commitOut.en) stray++;
      end
      checkOutput("notifyHold", 64'(stray), 64'd0);
      notify_clr = 2'b01;
      applyStimulus();
      checkOutput("notifyClrEdge", 64'(commitOut.en), 64'd0);
      applyStimulus();
      checkOutput("notifyRetire", 64'(commitOut), 64'({1'b1, 5'd7, 32'h77}));

      // Asynchronous reset with five entries in flight
      for (int i = 0; i < 5; i++) begin
         pushWb(5'(11 + i), 32'(i + 1), 1'b1, 2'b00);
         applyStimulus();
      end
      checkOutput("preResetActive", 64'(commitOut.en), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncCommit", 64'(commitOut), 64'd0);
      checkOutput("asyncBrEnMissTaken", 64'({branchOut.en, branchOut.miss, branchOut.taken}), 64'd0);
      checkOutput("asyncBrPc", 64'(branchOut.current_pc), 64'd0);
      checkOutput("asyncBrJump", 64'(branchOut.jump_addr), 64'd0);
      checkOutput("asyncFlush", 64'(flushOut), 64'd0);
      checkOutput("asyncFull", 64'(full), 64'd0);
      checkOutput("asyncId", 64'(pushBus.commit_id), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("postResetId", 64'(pushBus.commit_id), 64'd0);
      pushWb(5'd1, 32'h0, 1'b0, 2'b00);
      applyStimulus();
      checkOutput("postResetNextId", 64'(pushBus.commit_id), 64'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
